// File: rtl/rbm_sequencer.sv
// rbm_sequencer: term-streaming controller for the Main RBM datapath.
// Each iteration walks every hidden neuron over all visible terms plus a bias,
// then every classifier output over all hidden terms plus a bias, capturing
// the datapath result one cycle after each bias term.
//
// Handshake: there is no valid/ready pair here. The block is the initiating
// end of a fixed-rate stream. One term is presented per cycle while a phase
// enable is high, and the datapath result (hidden / spike) is sampled in the
// capture cycle that follows each bias term.
module rbm_sequencer #(
   parameter int N_VIS = 784,
   parameter int N_HID = 441,
   parameter int N_CLS = 10,
   parameter int CNT_W = 8,
   localparam int PW = $clog2(N_VIS + 1),
   localparam int HW = $clog2(N_HID + 1),
   localparam int SW = (N_CLS > 1) ? $clog2(N_CLS) : 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic [7:0]               iteration_num,
   input  logic                     image_bit,
   input  logic                     hidden,
   input  logic                     spike,
   output logic [PW-1:0]            pixel_id,
   output logic [HW-1:0]            hidden_id,
   output logic [SW-1:0]            spike_id,
   output logic                     bias_term,
   output logic                     pixel,
   output logic                     hidden_pixel,
   output logic                     enable_hidden,
   output logic                     enable_classi,
   output logic                     busy,
   output logic                     done,
   output logic [N_CLS*CNT_W-1:0]   spike_count,
   output logic [2:0]               state_dbg
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HID     = 3'd1,
      HID_CAP = 3'd2,
      CLS     = 3'd3,
      CLS_CAP = 3'd4,
      DONE    = 3'd5
   } state_t;

   localparam logic [PW-1:0]    PIX_BIAS = PW'(N_VIS);
   localparam logic [HW-1:0]    HID_BIAS = HW'(N_HID);
   localparam logic [HW-1:0]    HID_LAST = HW'(N_HID - 1);
   localparam logic [SW-1:0]    SPK_LAST = SW'(N_CLS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_t            state_q, state_d;
   logic [PW-1:0]     pix_d;
   logic [HW-1:0]     hid_d;
   logic [SW-1:0]     spk_d;
   logic [7:0]        iter_q, iter_d;
   logic [7:0]        iter_num_q, iter_num_d;
   logic [N_HID-1:0]  store_q, store_d;
   logic [CNT_W-1:0]  cnt_q [N_CLS];
   logic [CNT_W-1:0]  cnt_d [N_CLS];
   logic              bias_d, hp_d, en_h_d, en_c_d, busy_d, done_d;

   // Next-state, index, store and counter logic; outputs are derived from the
   // next values so that every output except pixel comes straight from a flop.
   always_comb begin
      state_d    = state_q;
      pix_d      = pixel_id;
      hid_d      = hidden_id;
      spk_d      = spike_id;
      iter_d     = iter_q;
      iter_num_d = iter_num_q;
      store_d    = store_q;
      for (int k = 0; k < N_CLS; k++) cnt_d[k] = cnt_q[k];

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               for (int k = 0; k < N_CLS; k++) cnt_d[k] = '0;
               store_d    = '0;
               iter_d     = '0;
               iter_num_d = iteration_num;
               pix_d      = '0;
               hid_d      = '0;
               spk_d      = '0;
               state_d    = (iteration_num == 8'd0) ? DONE : HID;
            end
         end
         HID: begin
            if (pixel_id == PIX_BIAS) state_d = HID_CAP;
            else                      pix_d   = pixel_id + 1'b1;
         end
         HID_CAP: begin
            for (int n = 0; n < N_HID; n++)
               if (hidden_id == HW'(n)) store_d[n] = hidden;
            pix_d = '0;
            if (hidden_id < HID_LAST) begin
               hid_d   = hidden_id + 1'b1;
               state_d = HID;
            end else begin
               hid_d   = '0;
               spk_d   = '0;
               state_d = CLS;
            end
         end
         CLS: begin
            if (hidden_id == HID_BIAS) state_d = CLS_CAP;
            else                       hid_d   = hidden_id + 1'b1;
         end
         CLS_CAP: begin
            for (int k = 0; k < N_CLS; k++)
               if (spike_id == SW'(k) && spike && cnt_q[k] != CNT_MAX)
                  cnt_d[k] = cnt_q[k] + 1'b1;
            hid_d = '0;
            if (spike_id < SPK_LAST) begin
               spk_d   = spike_id + 1'b1;
               state_d = CLS;
            end else begin
               spk_d   = '0;
               pix_d   = '0;
               iter_d  = iter_q + 8'd1;
               state_d = (iter_d == iter_num_q) ? DONE : HID;
            end
         end
         default: state_d = IDLE;
      endcase

      en_h_d = (state_d == HID) || (state_d == HID_CAP);
      en_c_d = (state_d == CLS) || (state_d == CLS_CAP);
      busy_d = en_h_d || en_c_d;
      done_d = (state_d == DONE);
      bias_d = ((state_d == HID) && (pix_d == PIX_BIAS)) ||
               ((state_d == CLS) && (hid_d == HID_BIAS));

      // Uses store_d so a neuron captured on this edge is already visible.
      hp_d = 1'b0;
      if (state_d == CLS) begin
         if (hid_d == HID_BIAS) hp_d = 1'b1;
         else
            for (int n = 0; n < N_HID; n++)
               if (hid_d == HW'(n)) hp_d = store_d[n];
      end
   end

   // State, indices, hidden store, counters and registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         pixel_id      <= '0;
         hidden_id     <= '0;
         spike_id      <= '0;
         iter_q        <= '0;
         iter_num_q    <= '0;
         store_q       <= '0;
         for (int k = 0; k < N_CLS; k++) cnt_q[k] <= '0;
         bias_term     <= 1'b0;
         hidden_pixel  <= 1'b0;
         enable_hidden <= 1'b0;
         enable_classi <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         state_q       <= state_d;
         pixel_id      <= pix_d;
         hidden_id     <= hid_d;
         spike_id      <= spk_d;
         iter_q        <= iter_d;
         iter_num_q    <= iter_num_d;
         store_q       <= store_d;
         for (int k = 0; k < N_CLS; k++) cnt_q[k] <= cnt_d[k];
         bias_term     <= bias_d;
         hidden_pixel  <= hp_d;
         enable_hidden <= en_h_d;
         enable_classi <= en_c_d;
         busy          <= busy_d;
         done          <= done_d;
      end
   end

   // Bias terms always see a constant 1 on the visible input.
   assign pixel     = bias_term ? 1'b1 : image_bit;
   assign state_dbg = state_q;

   for (genvar k = 0; k < N_CLS; k++) begin : g_cnt
      assign spike_count[k*CNT_W +: CNT_W] = cnt_q[k];
   end

endmodule
